fir_mac_core: RTL and testbench
===============================

Name: fir_mac_core

Overview:
- Parametrised successor to the 4-tap parallel FIR.
- Time-multiplexed single-multiplier MAC FIR: N_TAPS taps, any widths, valid/ready streaming on input and output.
- Adds framed coefficient reload, round-half-up output scaling with saturation, and a per-sample overflow flag.
- Sits between the pin-level I/O adapter (sample/coefficient source) and the output serialiser.

Parameters:
- N_TAPS, 4, number of taps (>=2).
- BW_IN, 6, signed width of samples and coefficients.
- BW_OUT, 8, signed output width.
- SHIFT, 4, arithmetic right shift applied to the accumulator before saturation (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  beat on in_data is valid.
- in_ready  out  1  core accepts a beat this cycle.
- coef_load  in  1  qualifies the current beat as a coefficient (1) or a sample (0).
- in_data  in  BW_IN  signed sample or coefficient.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  BW_OUT  signed filtered, scaled, saturated result.
- out_sat  out  1  out_data was clipped; valid with out_valid.
- coef_ok  out  1  a full coefficient set is loaded.

Behaviour:
- Beat = in_valid & in_ready at a clock edge. ACC_W = 2*BW_IN + clog2(N_TAPS), signed. Products are 2*BW_IN signed and sign-extended into acc.
- Reset:
  - state = LOAD, coef_cnt = 0, all c[k] = 0, all x[k] = 0, acc = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_sat = 0, coef_ok = 0.
  - Reset asserted mid-MAC or mid-OUT aborts that operation; no result is emitted.
- States: LOAD, IDLE, MAC, OUT. in_ready = 1 in LOAD and IDLE only.
- LOAD:
  - Coefficient beat: c shifts (c[k] <= c[k-1]; c[0] <= in_data); coef_cnt++.
  - Sample beats are consumed and discarded.
  - When coef_cnt reaches N_TAPS: go to IDLE, set coef_ok.
  - Load order: c[N_TAPS-1] first, c[0] last.
- IDLE:
  - Sample beat: x shifts (x[0] <= in_data, x[k] <= x[k-1]); acc <= 0; k <= 0; go to MAC.
  - Coefficient beat: go to LOAD with coef_cnt = 1, the coefficient shifted in; coef_ok <= 0; all x <= 0.
- MAC:
  - One tap per cycle: acc <= acc + x[k]*c[k]; k++.
  - On the edge processing k = N_TAPS-1, register out_data/out_sat from the final sum, set out_valid, go to OUT.
- OUT:
  - out_valid and out_data are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
- Latency: sample accepted at edge e0 -> out_valid high after edge e0+N_TAPS.
- Throughput: at best one sample per N_TAPS+2 cycles.
- Scaling, with s = final signed sum:
  - r = (s + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT.
  - If r > 2^(BW_OUT-1)-1: out_data = max, out_sat = 1.
  - If r < -2^(BW_OUT-1): out_data = min, out_sat = 1.
  - Otherwise out_data = r[BW_OUT-1:0], out_sat = 0.
- coef_load is sampled only on beats; it is ignored when no beat occurs.

Decomposition:
- Shared package fir_pkg holds:
  - the state enum (LOAD/IDLE/MAC/OUT);
  - function acc_width(bw_in, n_taps);
  - function round_sat(acc, shift, bw_out) returning {sat, data}.
- One sub-module is natural: fir_round_sat (combinational scale/round/saturate, parametrised by ACC_W, SHIFT, BW_OUT).
- The tap index mux stays in the core.

Test Plan (defaults N_TAPS=4, BW_IN=6, BW_OUT=8, SHIFT=4):
- Reset, then load coefficients 31, -30, 20, 10 (c3..c0) -> coef_ok=1 after the 4th beat. Feed samples 31, 0, 0, 0, 0 with out_ready=1 -> out_data = 19, 39, -58, 60, 0, out_sat=0; each out_valid rises exactly 4 edges after its sample beat.
- All coefficients -32, samples -32 x4 -> sum 4096 -> 4th output out_data=127, out_sat=1. All coefficients -32, samples 31 x4 -> sum -3968 -> out_data=-128, out_sat=1.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> out_data stable, in_ready=0 throughout, no sample lost. Release -> next beat accepted 1 cycle after the output handshake.
- Samples sent during LOAD -> discarded. Coefficient reload in IDLE after samples -> coef_ok drops to 0; after the new set is loaded, the first output reflects a zeroed delay line (impulse 31 with c0=10 -> 19).
- Assert reset during MAC (cycle 2 of 4) -> out_valid stays 0, coef_ok=0, in_ready=1 next cycle, state LOAD.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed MAC FIR core.
//   fir_state_e : core control states (LOAD / IDLE / MAC / OUT)
//   acc_width() : signed accumulator width for a given sample width and tap count
//   round_sat() : round-half-up arithmetic right shift followed by signed
//                 saturation to bw_out bits; returns {sat, data}. It works on a
//                 wide fixed-width container so one function serves every
//                 parameterisation. Callers sign-extend into it and slice the
//                 low bw_out bits of data.
// -----------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      IDLE = 2'd1,
      MAC  = 2'd2,
      OUT  = 2'd3
   } fir_state_e;

   // Working width of round_sat. It must exceed the accumulator width by at
   // least one bit so the rounding bias can never wrap.
   localparam int RS_W = 64;

   typedef struct packed {
      logic                   sat;
      logic signed [RS_W-1:0] data;
   } rs_t;

   function automatic int acc_width(input int bw_in, input int n_taps);
      return 2 * bw_in + $clog2(n_taps);
   endfunction

   function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                     input int                     shift,
                                     input int                     bw_out);
      logic signed [RS_W-1:0] bias;
      logic signed [RS_W-1:0] lim;
      logic signed [RS_W-1:0] r;
      rs_t                    res;
      // Half an output LSB; with SHIFT = 0 there is nothing to round.
      bias = '0;
      if (shift > 0) begin
         bias[shift-1] = 1'b1;
      end
      // lim = 2^(bw_out-1): max = lim-1, min = -lim.
      lim = '0;
      lim[bw_out-1] = 1'b1;
      r = (acc + bias) >>> shift;
      res.sat  = 1'b0;
      res.data = r;
      if (r > lim - 64'sd1) begin
         res.sat  = 1'b1;
         res.data = lim - 64'sd1;
      end else if (r < -lim) begin
         res.sat  = 1'b1;
         res.data = -lim;
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_mac_core_if.sv
// -----------------------------------------------------------------------------
// fir_mac_core_if
// Streaming interface of the MAC FIR core.
//   in_valid / in_ready / coef_load / in_data : input beat (sample or coefficient)
//   out_valid / out_ready / out_data / out_sat: result stream with clip flag
//   coef_ok                                   : full coefficient set present
// Modports:
//   master : the block feeding samples and consuming results
//   slave  : the filter core
// -----------------------------------------------------------------------------
interface fir_mac_core_if #(
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8
);

   logic                     in_valid;
   logic                     in_ready;
   logic                     coef_load;
   logic signed [BW_IN-1:0]  in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [BW_OUT-1:0] out_data;
   logic                     out_sat;
   logic                     coef_ok;

   modport master (
      output in_valid,
      output coef_load,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat,
      input  coef_ok
   );

   modport slave (
      input  in_valid,
      input  coef_load,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat,
      output coef_ok
   );

endinterface

// File: rtl/fir_round_sat.sv
// -----------------------------------------------------------------------------
// fir_round_sat
// Combinational output scaler: rounds the accumulator half-up while shifting
// right by SHIFT, then clips to a signed BW_OUT-bit range.
//   acc  in  ACC_W   signed final accumulator value
//   data out BW_OUT  scaled, saturated result
//   sat  out 1       data was clipped
// -----------------------------------------------------------------------------
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int ACC_W  = 14,
   parameter int SHIFT  = 4,
   parameter int BW_OUT = 8
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [BW_OUT-1:0] data,
   output logic                     sat
);

   rs_t  rs;
   logic unused_hi;

   // NOTE: combinational blocks use blocking '=' and give every output a value
   // on every path, so no latch can be inferred.
   always_comb begin
      rs   = round_sat({{(RS_W-ACC_W){acc[ACC_W-1]}}, acc}, SHIFT, BW_OUT);
      data = rs.data[BW_OUT-1:0];
      sat  = rs.sat;
   end

   // After clipping, the upper bits are sign copies of data and carry nothing.
   assign unused_hi = ^rs.data[RS_W-1:BW_OUT];

endmodule

// File: rtl/fir_mac_core.sv
// -----------------------------------------------------------------------------
// fir_mac_core
// Time-multiplexed FIR with one multiplier: each accepted sample is convolved
// with the N_TAPS coefficients over N_TAPS cycles. The result is rounded,
// shifted and saturated, then held until the consumer takes it.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high; aborts any operation in flight
//   bus    : fir_mac_core_if.slave (input beats, result stream, coef_ok)
// Coefficients arrive c[N_TAPS-1] first, c[0] last, as beats with coef_load=1.
// A coefficient beat while a set is loaded starts a fresh set and clears the
// delay line.
// -----------------------------------------------------------------------------
module fir_mac_core
   import fir_pkg::*;
#(
   parameter int N_TAPS = 4,
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8,
   parameter int SHIFT  = 4
) (
   input logic          clk,
   input logic          reset,
   fir_mac_core_if.slave bus
);

   localparam int ACC_W  = acc_width(BW_IN, N_TAPS);
   localparam int PROD_W = 2 * BW_IN;
   localparam int KW     = $clog2(N_TAPS);
   localparam int CW     = $clog2(N_TAPS + 1);
   localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(N_TAPS - 1);

   fir_state_e               state_q,     state_d;
   logic [CW-1:0]            coef_cnt_q,  coef_cnt_d;
   logic signed [BW_IN-1:0]  c_q [N_TAPS];
   logic signed [BW_IN-1:0]  c_d [N_TAPS];
   logic signed [BW_IN-1:0]  x_q [N_TAPS];
   logic signed [BW_IN-1:0]  x_d [N_TAPS];
   logic signed [ACC_W-1:0]  acc_q,       acc_d;
   logic [KW-1:0]            k_q,         k_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [BW_OUT-1:0] out_data_q,  out_data_d;
   logic                     out_sat_q,   out_sat_d;
   logic                     coef_ok_q,   coef_ok_d;

   logic                     beat;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  mac_sum;
   logic signed [BW_OUT-1:0] rs_data;
   logic                     rs_sat;

   assign bus.in_ready  = (state_q == LOAD) || (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.coef_ok   = coef_ok_q;

   assign beat = bus.in_valid && bus.in_ready;

   // Tap mux feeding the single multiplier.
   assign prod    = x_q[k_q] * c_q[k_q];
   assign mac_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   // Scales the sum that includes the last tap, so the result can be
   // registered on the same edge that processes that tap.
   fir_round_sat #(
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT),
      .BW_OUT (BW_OUT)
   ) u_round_sat (
      .acc  (mac_sum),
      .data (rs_data),
      .sat  (rs_sat)
   );

   always_comb begin
      state_d     = state_q;
      coef_cnt_d  = coef_cnt_q;
      c_d         = c_q;
      x_d         = x_q;
      acc_d       = acc_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      coef_ok_d   = coef_ok_q;

      unique case (state_q)
         LOAD: begin
            // Sample beats are accepted here but have no effect.
            if (beat && bus.coef_load) begin
               coef_cnt_d = coef_cnt_q + 1'b1;
               if (coef_cnt_q == C_LAST) begin
                  coef_ok_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         IDLE: begin
            if (beat) begin
               if (bus.coef_load) begin
                  // Starting a new set: stale history must not mix with it.
                  coef_cnt_d = CW'(1);
                  coef_ok_d  = 1'b0;
                  for (int k = 0; k < N_TAPS; k++) begin
                     x_d[k] = '0;
                  end
                  state_d = LOAD;
               end else begin
                  x_d[0] = bus.in_data;
                  for (int k = 1; k < N_TAPS; k++) begin
                     x_d[k] = x_q[k-1];
                  end
                  acc_d   = '0;
                  k_d     = '0;
                  state_d = MAC;
               end
            end
         end
         MAC: begin
            acc_d = mac_sum;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               out_data_d  = rs_data;
               out_sat_d   = rs_sat;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = LOAD;
      endcase

      // Beats happen only in LOAD and IDLE. In both states a coefficient
      // beat shifts the coefficient line.
      if (beat && bus.coef_load) begin
         c_d[0] = bus.in_data;
         for (int k = 1; k < N_TAPS; k++) begin
            c_d[k] = c_q[k-1];
         end
      end
   end

   // NOTE: state registers use non-blocking '<=' so that every flop samples the
   // values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LOAD;
         coef_cnt_q  <= '0;
         acc_q       <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         coef_ok_q   <= 1'b0;
         // NOTE: the coefficient and delay-line arrays are reset. The first
         // result after a reload has to see a zeroed history, and these
         // arrays are only N_TAPS words.
         for (int k = 0; k < N_TAPS; k++) begin
            c_q[k] <= '0;
            x_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         coef_cnt_q  <= coef_cnt_d;
         c_q         <= c_d;
         x_q         <= x_d;
         acc_q       <= acc_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         coef_ok_q   <= coef_ok_d;
      end
   end

endmodule

// File: tb/tb_fir_mac_core.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_core
// Bench for fir_mac_core. Stimulus tasks feed beats and update a reference
// model. The model pushes each expected result into a scoreboard queue. An
// independent monitor compares every presented result against the head of
// the queue and pops the entry on each output handshake.
// -----------------------------------------------------------------------------
module tb_fir_mac_core;

   localparam int N_TAPS = 4;
   localparam int BW_IN  = 6;
   localparam int BW_OUT = 8;
   localparam int SHIFT  = 4;
   localparam int PERIOD = 10;

   logic clk;
   logic reset;

   fir_mac_core_if #(.BW_IN(BW_IN), .BW_OUT(BW_OUT)) bus ();

   fir_mac_core #(
      .N_TAPS (N_TAPS),
      .BW_IN  (BW_IN),
      .BW_OUT (BW_OUT),
      .SHIFT  (SHIFT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int     data;
      bit     sat;
      longint t;
   } exp_t;

   exp_t   sb[$];
   int     coefs[$];   // coefs[k] is c[k]
   int     hist[$];    // hist[k] is x[k], the newest sample first
   int     cnt_m;
   bit     loaded_m;
   int     ready_mode; // 0: out_ready low, 1: high, 2: random
   longint hs_t;       // edge time of the latest output handshake

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scaling rule as plain integer arithmetic: floor((s + half) / 2^SHIFT),
   // then clip to the signed output range.
   function automatic void scale(input int s, output int d, output bit sat);
      int div;
      int num;
      int r;
      int maxv;
      int minv;
      div  = 1 << SHIFT;
      num  = s + ((SHIFT > 0) ? div / 2 : 0);
      r    = (num >= 0) ? num / div : -((-num + div - 1) / div);
      maxv = (1 << (BW_OUT - 1)) - 1;
      minv = -(1 << (BW_OUT - 1));
      sat  = 1'b0;
      d    = r;
      if (r > maxv) begin
         d   = maxv;
         sat = 1'b1;
      end else if (r < minv) begin
         d   = minv;
         sat = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      sb.delete();
      coefs.delete();
      hist.delete();
      cnt_m    = 0;
      loaded_m = 1'b0;
   endfunction

   function automatic void model_beat(input bit is_coef, input int v, input longint t);
      exp_t e;
      int   s;
      if (is_coef) begin
         if (loaded_m) begin
            loaded_m = 1'b0;
            cnt_m    = 0;
            hist.delete();
         end
         coefs.push_front(v);
         if (coefs.size() > N_TAPS) void'(coefs.pop_back());
         cnt_m++;
         if (cnt_m == N_TAPS) loaded_m = 1'b1;
      end else if (loaded_m) begin
         hist.push_front(v);
         if (hist.size() > N_TAPS) void'(hist.pop_back());
         s = 0;
         for (int k = 0; k < hist.size(); k++) s += hist[k] * coefs[k];
         scale(s, e.data, e.sat);
         e.t = t;
         sb.push_back(e);
      end
   endfunction

   // One input beat. Inputs change #1 after a rising edge, and in_ready is
   // sampled on the falling edge. The wait is bounded.
   task automatic send(input bit is_coef, input int v, output longint beat_t);
      logic rdy;
      int   n;
      bus.in_valid  = 1'b1;
      bus.coef_load = is_coef;
      bus.in_data   = v[BW_IN-1:0];
      rdy    = 1'b0;
      n      = 0;
      beat_t = 0;
      while (!rdy && n < 100) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         n++;
      end
      check("beat_accepted", rdy, 1);
      if (rdy) begin
         beat_t = $time;
         model_beat(is_coef, v, beat_t);
      end
      #1;
      bus.in_valid  = 1'b0;
      bus.coef_load = 1'($urandom_range(0, 1));
      check("coef_ok", bus.coef_ok, loaded_m);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", sb.size(), 0);
   endtask

   // The only driver of out_ready.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: a result must be pending in the scoreboard. It must match the
   // head entry on every cycle that it is presented, and it must rise
   // exactly N_TAPS edges after its sample beat.
   initial begin
      bit prev_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_v = 1'b0;
         end else begin
            if (bus.out_valid) begin
               check("out_expected", (sb.size() > 0) ? 1 : 0, 1);
               if (sb.size() > 0) begin
                  if (!prev_v) check("latency", ($time - PERIOD/2) - sb[0].t, N_TAPS * PERIOD);
                  check("out_data", bus.out_data, sb[0].data);
                  check("out_sat", bus.out_sat, sb[0].sat);
                  if (bus.out_ready) begin
                     hs_t = $time + PERIOD/2;
                     void'(sb.pop_front());
                  end
               end
            end
            prev_v = bus.out_valid;
         end
      end
   end

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint bt;
      longint bt2;
      int     v;
      int     impulse [5];
      impulse = '{31, 0, 0, 0, 0};
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.coef_load = 1'b0;
      bus.in_data   = '0;
      ready_mode    = 1;
      hs_t          = 0;
      model_reset();
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_sat", bus.out_sat, 0);
      check("rst_coef_ok", bus.coef_ok, 0);
      @(posedge clk);
      #1;

      // A sample during LOAD is discarded. Then load c3..c0 and send the impulse.
      send(1'b0, 17, bt);
      send(1'b1, 31, bt);
      send(1'b1, -30, bt);
      send(1'b1, 20, bt);
      send(1'b1, 10, bt);
      for (int i = 0; i < 5; i++) send(1'b0, impulse[i], bt);
      drain();

      // Saturation, both polarities (each reload starts from IDLE).
      for (int i = 0; i < N_TAPS; i++) send(1'b1, -32, bt);
      for (int i = 0; i < 4; i++) send(1'b0, -32, bt);
      drain();
      for (int i = 0; i < N_TAPS; i++) send(1'b1, -32, bt);
      for (int i = 0; i < 4; i++) send(1'b0, 31, bt);
      drain();

      // Backpressure: the result is held, in_ready stays low, and the pending
      // beat is taken one cycle after the handshake.
      ready_mode = 0;
      send(1'b0, 5, bt);
      fork
         send(1'b0, -7, bt2);
         begin
            repeat (10) begin
               @(negedge clk);
               check("bp_in_ready_low", bus.in_ready, 0);
            end
            ready_mode = 1;
         end
      join
      check("bp_next_beat_gap", bt2 - hs_t, PERIOD);
      drain();

      // Reload from IDLE after samples: the delay line restarts from zero.
      send(1'b1, 31, bt);
      send(1'b1, -30, bt);
      send(1'b1, 20, bt);
      send(1'b1, 10, bt);
      send(1'b0, 31, bt);
      send(1'b0, 0, bt);
      drain();

      // Randomised rounds with random backpressure and idle gaps.
      ready_mode = 2;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N_TAPS; i++) begin
            v = int'($urandom_range(0, 63)) - 32;
            send(1'b1, v, bt);
         end
         for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 63)) - 32;
            send(1'b0, v, bt);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
               bus.coef_load = 1'($urandom_range(0, 1));
            end
         end
         drain();
      end
      ready_mode = 1;

      // Reset in the second MAC cycle aborts the result.
      send(1'b0, 23, bt);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_coef_ok", bus.coef_ok, 0);
      check("abort_in_ready", bus.in_ready, 1);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_output", bus.out_valid, 0);
      end
      // Still in LOAD: a sample is swallowed without producing a result.
      @(posedge clk);
      #1;
      send(1'b0, 9, bt);
      repeat (8) begin
         @(negedge clk);
         check("load_no_output", bus.out_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
